// File: rtl/counter_checker.sv
// counter_checker: shadow model of an up/down/load counter that checks a
// monitored counter cycle by cycle and keeps mismatch statistics.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   clear                  synchronous clear of statistics, back to UNSYNC
//   mon_valid              qualifies all mon_* inputs
//   mon_load, mon_load_val monitored load control / value
//   mon_en, mon_up         monitored count enable / direction (1 = up)
//   mon_count              monitored counter output
//   exp_count              predicted mon_count for the next valid cycle
//   synced, halted         state flags (CHECK or HALT / HALT)
//   mismatch               one-cycle pulse after a failed compare
//   err_cnt, chk_cnt       saturating mismatch / compare counters
//   first_err_exp/_act     expected / actual values of the first mismatch
module counter_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SAT_MODE    = 0,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             mon_valid,
  input  logic             mon_load,
  input  logic [WIDTH-1:0] mon_load_val,
  input  logic             mon_en,
  input  logic             mon_up,
  input  logic [WIDTH-1:0] mon_count,
  output logic [WIDTH-1:0] exp_count,
  output logic             synced,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act,
  output logic             halted
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] STAT_MAX = '1;

  typedef enum logic [1:0] {UNSYNC, CHECK, HALT} state_t;

  state_t state;

  // Model update for one compare cycle: load > enable > hold.
  function automatic logic [WIDTH-1:0] next_exp(input logic [WIDTH-1:0] cur,
                                                input logic             load,
                                                input logic [WIDTH-1:0] load_val,
                                                input logic             en,
                                                input logic             up);
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    if (load) begin
      nxt = load_val;
    end else if (en && up) begin
      if (!(SAT_MODE != 0 && cur == CNT_MAX)) nxt = cur + WIDTH'(1);
    end else if (en) begin
      if (!(SAT_MODE != 0 && cur == '0)) nxt = cur - WIDTH'(1);
    end
    return nxt;
  endfunction

  // Checker state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state         <= UNSYNC;
      exp_count     <= '0;
      synced        <= 1'b0;
      mismatch      <= 1'b0;
      err_cnt       <= '0;
      chk_cnt       <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
      halted        <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (mon_valid) begin
        unique case (state)
          UNSYNC: begin
            if (mon_load) begin
              exp_count <= mon_load_val;
              state     <= CHECK;
              synced    <= 1'b1;
            end
          end
          CHECK: begin
            if (chk_cnt != STAT_MAX) chk_cnt <= chk_cnt + CNT_W'(1);
            if (mon_count != exp_count) begin
              mismatch <= 1'b1;
              if (err_cnt != STAT_MAX) err_cnt <= err_cnt + CNT_W'(1);
              // err_cnt saturates rather than wraps, so zero means "no error yet".
              if (err_cnt == '0) begin
                first_err_exp <= exp_count;
                first_err_act <= mon_count;
              end
              if (STOP_ON_ERR != 0) begin
                state  <= HALT;
                halted <= 1'b1;
              end
            end
            // The model never resyncs to mon_count; only a load re-aligns it.
            exp_count <= next_exp(exp_count, mon_load, mon_load_val, mon_en, mon_up);
          end
          HALT: begin
          end
          default: begin
            state  <= UNSYNC;
            synced <= 1'b0;
            halted <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: four instances (wrap, saturating,
// stop-on-error, narrow statistics) share one stimulus stream; a behavioural
// model pushes expected outputs per cycle and a monitor pops and compares.
module tb_counter_checker;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, clear, mon_valid, mon_load, mon_en, mon_up;
  logic [3:0] mon_load_val, mon_count;

  logic [3:0]  exp_o [NI];
  logic        syn_o [NI];
  logic        mis_o [NI];
  logic        hlt_o [NI];
  logic [3:0]  fe_o  [NI];
  logic [3:0]  fa_o  [NI];
  logic [15:0] err_o [3];
  logic [15:0] chk_o [3];
  logic [1:0]  err3, chk3;

  counter_checker #(.WIDTH(4), .CNT_W(16), .SAT_MODE(0), .STOP_ON_ERR(0)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .mon_valid(mon_valid), .mon_load(mon_load),
    .mon_load_val(mon_load_val), .mon_en(mon_en), .mon_up(mon_up), .mon_count(mon_count),
    .exp_count(exp_o[0]), .synced(syn_o[0]), .mismatch(mis_o[0]), .err_cnt(err_o[0]),
    .chk_cnt(chk_o[0]), .first_err_exp(fe_o[0]), .first_err_act(fa_o[0]), .halted(hlt_o[0]));

  counter_checker #(.WIDTH(4), .CNT_W(16), .SAT_MODE(1), .STOP_ON_ERR(0)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .mon_valid(mon_valid), .mon_load(mon_load),
    .mon_load_val(mon_load_val), .mon_en(mon_en), .mon_up(mon_up), .mon_count(mon_count),
    .exp_count(exp_o[1]), .synced(syn_o[1]), .mismatch(mis_o[1]), .err_cnt(err_o[1]),
    .chk_cnt(chk_o[1]), .first_err_exp(fe_o[1]), .first_err_act(fa_o[1]), .halted(hlt_o[1]));

  counter_checker #(.WIDTH(4), .CNT_W(16), .SAT_MODE(0), .STOP_ON_ERR(1)) u_stop (
    .clk(clk), .reset(reset), .clear(clear), .mon_valid(mon_valid), .mon_load(mon_load),
    .mon_load_val(mon_load_val), .mon_en(mon_en), .mon_up(mon_up), .mon_count(mon_count),
    .exp_count(exp_o[2]), .synced(syn_o[2]), .mismatch(mis_o[2]), .err_cnt(err_o[2]),
    .chk_cnt(chk_o[2]), .first_err_exp(fe_o[2]), .first_err_act(fa_o[2]), .halted(hlt_o[2]));

  counter_checker #(.WIDTH(4), .CNT_W(2), .SAT_MODE(0), .STOP_ON_ERR(0)) u_narrow (
    .clk(clk), .reset(reset), .clear(clear), .mon_valid(mon_valid), .mon_load(mon_load),
    .mon_load_val(mon_load_val), .mon_en(mon_en), .mon_up(mon_up), .mon_count(mon_count),
    .exp_count(exp_o[3]), .synced(syn_o[3]), .mismatch(mis_o[3]), .err_cnt(err3),
    .chk_cnt(chk3), .first_err_exp(fe_o[3]), .first_err_act(fa_o[3]), .halted(hlt_o[3]));

  // Per-instance configuration seen by the reference model.
  int p_sat  [NI] = '{0, 1, 0, 0};
  int p_stop [NI] = '{0, 0, 1, 0};
  int p_max  [NI] = '{65535, 65535, 65535, 3};

  // Reference model state: mode 0 = unsynced, 1 = checking, 2 = halted.
  int m_mode [NI];
  int m_exp  [NI];
  int m_err  [NI];
  int m_chk  [NI];
  int m_fe   [NI];
  int m_fa   [NI];
  int m_mis  [NI];
  bit m_seen [NI];

  typedef struct {
    int inst;
    int expc, syn, mis, err, chk, fe, fa, hlt;
  } exp_t;

  exp_t sbq[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int dut_err(input int i);
    return (i == 3) ? int'(err3) : int'(err_o[i]);
  endfunction

  function automatic int dut_chk(input int i);
    return (i == 3) ? int'(chk3) : int'(chk_o[i]);
  endfunction

  // Next counter value in the model's own terms: clamp or modulo 16.
  function automatic int bump(input int i, input int e, input int d);
    int n;
    n = e + d;
    if (p_sat[i] != 0) return (n > 15) ? 15 : ((n < 0) ? 0 : n);
    return (n + 16) % 16;
  endfunction

  function automatic void model_update(input int i, input bit r, input bit c, input bit v,
                                       input bit l, input int lv, input bit en, input bit up,
                                       input int cnt);
    if (r || c) begin
      m_mode[i] = 0; m_exp[i] = 0; m_err[i] = 0; m_chk[i] = 0;
      m_fe[i] = 0; m_fa[i] = 0; m_mis[i] = 0; m_seen[i] = 1'b0;
      return;
    end
    m_mis[i] = 0;
    if (!v) return;
    if (m_mode[i] == 0) begin
      if (l) begin
        m_exp[i]  = lv;
        m_mode[i] = 1;
      end
    end else if (m_mode[i] == 1) begin
      if (m_chk[i] < p_max[i]) m_chk[i]++;
      if (cnt != m_exp[i]) begin
        if (!m_seen[i]) begin
          m_seen[i] = 1'b1;
          m_fe[i]   = m_exp[i];
          m_fa[i]   = cnt;
        end
        if (m_err[i] < p_max[i]) m_err[i]++;
        m_mis[i] = 1;
        if (p_stop[i] != 0) m_mode[i] = 2;
      end
      if (l) m_exp[i] = lv;
      else if (en) m_exp[i] = bump(i, m_exp[i], up ? 1 : -1);
    end
  endfunction

  // Drive one cycle of stimulus and queue the expected post-edge outputs.
  task automatic step(input bit r, input bit c, input bit v, input bit l, input int lv,
                      input bit en, input bit up, input int cnt);
    exp_t e;
    @(negedge clk);
    reset = r; clear = c; mon_valid = v; mon_load = l;
    mon_load_val = 4'(lv); mon_en = en; mon_up = up; mon_count = 4'(cnt);
    for (int i = 0; i < NI; i++) begin
      model_update(i, r, c, v, l, lv, en, up, cnt);
      e.inst = i;
      e.expc = m_exp[i];
      e.syn  = (m_mode[i] != 0) ? 1 : 0;
      e.hlt  = (m_mode[i] == 2) ? 1 : 0;
      e.mis  = m_mis[i];
      e.err  = m_err[i];
      e.chk  = m_chk[i];
      e.fe   = m_fe[i];
      e.fa   = m_fa[i];
      sbq.push_back(e);
    end
  endtask

  // Wait until the last driven cycle has been clocked in.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are refreshed each rising edge; compare just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        check($sformatf("u%0d_exp_count", e.inst), int'(exp_o[e.inst]), e.expc);
        check($sformatf("u%0d_synced", e.inst), int'(syn_o[e.inst]), e.syn);
        check($sformatf("u%0d_halted", e.inst), int'(hlt_o[e.inst]), e.hlt);
        check($sformatf("u%0d_mismatch", e.inst), int'(mis_o[e.inst]), e.mis);
        check($sformatf("u%0d_err_cnt", e.inst), dut_err(e.inst), e.err);
        check($sformatf("u%0d_chk_cnt", e.inst), dut_chk(e.inst), e.chk);
        check($sformatf("u%0d_first_err_exp", e.inst), int'(fe_o[e.inst]), e.fe);
        check($sformatf("u%0d_first_err_act", e.inst), int'(fa_o[e.inst]), e.fa);
      end
    end
  end

  initial begin
    int cnt;
    bit r, c, v, l, en, up;
    reset = 1'b1; clear = 1'b0; mon_valid = 1'b0; mon_load = 1'b0;
    mon_load_val = '0; mon_en = 1'b0; mon_up = 1'b0; mon_count = '0;

    // Reset state
    step(1, 0, 1, 1, 9, 1, 1, 3);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check("rst_exp_count", int'(exp_o[0]), 0);
    check("rst_synced", int'(syn_o[0]), 0);
    check("rst_chk_cnt", int'(chk_o[0]), 0);

    // Load 5 then count up with a correct DUT
    step(0, 0, 1, 1, 5, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 1, 5);
    step(0, 0, 1, 0, 0, 1, 1, 6);
    step(0, 0, 1, 0, 0, 1, 1, 7);
    settle();
    check("basic_exp_count", int'(exp_o[0]), 8);
    check("basic_chk_cnt", int'(chk_o[0]), 3);
    check("basic_err_cnt", int'(err_o[0]), 0);

    // First error then a second one; stop instance halts on the first
    step(0, 0, 1, 0, 0, 0, 0, 9);
    settle();
    check("err1_mismatch", int'(mis_o[0]), 1);
    check("err1_first_exp", int'(fe_o[0]), 8);
    check("err1_first_act", int'(fa_o[0]), 9);
    check("stop_halted", int'(hlt_o[2]), 1);
    step(0, 0, 1, 0, 0, 0, 0, 2);
    step(0, 0, 1, 0, 0, 1, 1, 3);
    settle();
    check("err2_err_cnt", int'(err_o[0]), 3);
    check("err2_first_act", int'(fa_o[0]), 9);
    check("stop_err_cnt", int'(err_o[2]), 1);
    check("stop_chk_frozen", int'(chk_o[2]), 4);

    // Clear wins over a simultaneous valid sample
    step(0, 1, 1, 1, 7, 1, 1, 0);
    settle();
    check("clear_synced", int'(syn_o[2]), 0);
    check("clear_err_cnt", int'(err_o[2]), 0);

    // Wrap vs saturate at the top and bottom
    step(0, 0, 1, 1, 14, 0, 0, 0);
    settle();
    check("wrap_load14", int'(exp_o[0]), 14);
    step(0, 0, 1, 0, 0, 1, 1, m_exp[0]);
    step(0, 0, 1, 0, 0, 1, 1, m_exp[0]);
    settle();
    check("wrap_top", int'(exp_o[0]), 0);
    check("sat_top", int'(exp_o[1]), 15);
    step(0, 0, 1, 0, 0, 1, 1, m_exp[0]);
    settle();
    check("wrap_after", int'(exp_o[0]), 1);
    step(0, 0, 1, 1, 0, 0, 0, m_exp[0]);
    step(0, 0, 1, 0, 0, 1, 0, m_exp[0]);
    settle();
    check("wrap_bottom", int'(exp_o[0]), 15);
    check("sat_bottom", int'(exp_o[1]), 0);

    // Load beats enable; invalid cycles change nothing
    step(0, 0, 1, 1, 3, 1, 1, m_exp[0]);
    step(0, 0, 0, 1, 9, 1, 1, 12);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    settle();
    check("load_prio_exp", int'(exp_o[0]), 3);
    check("idle_chk_cnt", int'(chk_o[0]), m_chk[0]);

    // Reset mid-check with two errors, then resume only after a load
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 5);
    step(0, 0, 1, 0, 0, 0, 0, 5);
    settle();
    check("pre_rst_err_cnt", int'(err_o[0]), 2);
    step(1, 1, 1, 1, 4, 1, 1, 6);
    settle();
    check("midrst_err_cnt", int'(err_o[0]), 0);
    check("midrst_synced", int'(syn_o[0]), 0);
    step(0, 0, 1, 0, 0, 1, 1, 7);
    step(0, 0, 1, 1, 2, 0, 0, 7);
    step(0, 0, 1, 0, 0, 1, 1, 2);
    settle();
    check("resume_chk_cnt", int'(chk_o[0]), 1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      c  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 99) < 80);
      l  = ($urandom_range(0, 99) < 12);
      en = ($urandom_range(0, 99) < 70);
      up = $urandom_range(0, 1) != 0;
      cnt = ($urandom_range(0, 99) < 85) ? m_exp[0] : int'($urandom_range(0, 15));
      step(r, c, v, l, int'($urandom_range(0, 15)), en, up, cnt);
    end

    settle();
    #2;
    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the counter width under check.
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the width of the statistic counters.
REQ-003 The module SHALL have parameter SAT_MODE, default 0: 0 = wrap-around model, 1 = saturating model.
REQ-004 The module SHALL have parameter STOP_ON_ERR, default 0: 1 = freeze checking after first mismatch.
REQ-005 The module SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 clear  input  1  synchronous clear of statistics and return to UNSYNC.
REQ-009 mon_valid  input  1  monitored cycle valid; all mon_* sampled only when high.
REQ-010 mon_load  input  1  DUT load control this cycle.
REQ-011 mon_load_val  input  WIDTH  DUT load value.
REQ-012 mon_en  input  1  DUT count enable.
REQ-013 mon_up  input  1  direction: 1 = up, 0 = down.
REQ-014 mon_count  input  WIDTH  DUT counter output this cycle.
REQ-015 exp_count  output  WIDTH  model prediction of mon_count for the next valid cycle.
REQ-016 synced  output  1  high in CHECK or HALT.
REQ-017 mismatch  output  1  one-cycle pulse, registered, one cycle after a failed compare.
REQ-018 err_cnt, chk_cnt  output  CNT_W each  mismatch count, compare count.
REQ-019 first_err_exp, first_err_act  output  WIDTH each  expected/actual of first mismatch.
REQ-020 halted  output  1  high in HALT.

Function
REQ-021 State machine SHALL have states UNSYNC, CHECK, HALT.
REQ-022 UNSYNC: no compare; on mon_valid & mon_load, exp_count <= mon_load_val, next state CHECK.
REQ-023 CHECK, mon_valid high: compare mon_count against exp_count; chk_cnt +1; on inequality err_cnt +1 and mismatch pulses next cycle.
REQ-024 CHECK, same cycle as compare: exp_count update priority load > en > hold; load -> mon_load_val; en & up -> +1; en & !up -> -1.
REQ-025 SAT_MODE=0: +1 from 2^WIDTH-1 wraps to 0, -1 from 0 wraps to 2^WIDTH-1; SAT_MODE=1: holds at 2^WIDTH-1 and 0 respectively.
REQ-026 Model SHALL NOT resync to mon_count on mismatch; only a load re-aligns.
REQ-027 mon_valid low: no compare, no counter change, exp_count holds, in every state.
REQ-028 first_err_exp/act SHALL capture only on the first mismatch since reset/clear; later mismatches leave them unchanged.
REQ-029 err_cnt and chk_cnt SHALL saturate at 2^CNT_W-1.
REQ-030 STOP_ON_ERR=1: first mismatch moves CHECK -> HALT; HALT does no compares, no counter or exp_count changes; mismatch for that error still pulses.
REQ-031 STOP_ON_ERR=0: HALT is never entered.
REQ-032 clear SHALL zero err_cnt, chk_cnt, first_err_*, mismatch, exp_count and go to UNSYNC; clear wins over a simultaneous mon_valid sample.

Reset
REQ-033 reset SHALL override clear and all mon_* inputs.
REQ-034 On reset all outputs SHALL be 0 and state UNSYNC, including mid-CHECK and in HALT.

Verification
REQ-035 Reset, load 5, then en&up for 3 valid cycles with mon_count 5,6,7 -> exp_count 8, chk_cnt 3, err_cnt 0, mismatch never high.
REQ-036 Load 14, en&up x3 with correct DUT -> SAT_MODE=0 predicts 14,15,0,1; SAT_MODE=1 predicts 14,15,15,15; load 0 with en&!up -> SAT_MODE=0 predicts 15.
REQ-037 In CHECK with exp_count 8, drive mon_count 9 -> mismatch pulse one cycle later, err_cnt 1, first_err_exp 8, first_err_act 9; second error leaves first_err_* unchanged.
REQ-038 STOP_ON_ERR=1, inject one error then two more -> halted 1, err_cnt 1, chk_cnt frozen; clear -> UNSYNC, all stats 0.
REQ-039 mon_load & mon_en same cycle, load_val 3 -> exp_count 3; mon_valid low for 2 cycles -> exp_count and counters unchanged.
REQ-040 Reset asserted mid-CHECK with err_cnt 2 -> next cycle all outputs 0, synced 0, compares resume only after a new load.
